ysyx_23060236_div: RTL
======================

Name: ysyx_23060236_div

Overview:
Multi-cycle iterative 32-bit integer divider. It is the inverse-operation companion to the shift-add multiplier in the EXU, and uses the same valid/ready request and single-cycle outvalid result protocol. It serves RV32M DIV/DIVU/REM/REMU with restoring division, one quotient bit per cycle. Quotient and remainder are produced together, and the EXU selects which one it needs.

Parameters:
none (data width fixed at 32; iteration count fixed at 32)

Ports:
clock        input   1   system clock, all state updates on posedge
reset        input   1   reset, asynchronous, active-high
div_valid    input   1   request valid
div_ready    output  1   divider idle, can accept a request (= ~busy)
div_signed   input   1   1: operands two's-complement (DIV/REM); 0: unsigned (DIVU/REMU)
dividend     input   32  dividend, sampled on accept edge only
divisor      input   32  divisor, sampled on accept edge only
quotient     output  32  quotient, valid while div_outvalid=1
remainder    output  32  remainder, valid while div_outvalid=1
div_outvalid output  1   single-cycle pulse marking quotient/remainder valid

Behaviour:
- Reset (async, active-high): busy=0, div_outvalid=0, count=0, result register=0. div_ready=1 as soon as reset asserts. Data outputs read 0.
- Accept: on a posedge with div_valid & div_ready, the divider latches the following:
  - magnitudes |dividend| and |divisor| (negated only when div_signed and bit31 set);
  - q_neg = sd ^ sv (sd, sv = signed sign bits);
  - r_neg = sd;
  - dz = (divisor==0);
  - count=0, busy=1.
  - Working register {rem[32:0], quo[31:0]} is loaded with {33'b0, |dividend|}.
- While busy, div_valid is ignored and no operand is re-sampled.
- Iterate: each edge with busy & ~count[5]:
  - shift {rem,quo} left 1;
  - trial t = rem_shifted - {1'b0,|divisor|} (33-bit);
  - if t nonnegative: rem=t, quo lsb=1; else restore, lsb=0;
  - count+1.
- Fixup: edge with busy & count[5]:
  - quotient = dz ? 32'hFFFFFFFF : (q_neg ? -quo : quo);
  - remainder = dz ? dividend_original : (r_neg ? -rem : rem);
  - busy=0, count=0, div_outvalid=1.
- Latency: accept at edge T, iterations at edges T+1..T+32, fixup at T+33. div_outvalid is high for exactly the cycle after T+33. div_ready returns high in that same cycle.
- div_outvalid self-clears on the next edge.
- quotient/remainder hold their value until the next accept. A new request may be accepted in the outvalid cycle, and it overwrites the results on that edge.
- Divide by zero: fixed latency (no early exit). Quotient all ones, remainder = unmodified dividend, for both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the magnitude path. Quotient 0x80000000, remainder 0. No special case.
- The dividend original value is latched for the dz case, or equivalently re-derived from its magnitude and sd.
- Reset mid-operation: computation abandoned immediately, no outvalid pulse, ready=1.
- No flush input; the EXU must not issue a request it will discard while busy.

Decomposition:
- Shared package: XLEN=32 and CNT_W=6 constants, shared with the multiplier.
- No typedefs needed; single module.
- Optional sub-module ysyx_23060236_negabs (conditional two's-complement negate), reused for input abs and output fixup.
- Otherwise keep flat.

Test Plan:
- Unsigned 100/7 (div_signed=0) -> quotient=14, remainder=2; div_outvalid high exactly 34 cycles after the accept edge, for one cycle; div_ready low for the 33 cycles in between.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); unsigned 0xFFFFFFFF/0x10 -> quotient=0x0FFFFFFF, remainder=0xF.
- Divide by zero: signed 0xFFFFFFF9/0 and unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFF9 and 5 respectively, same 34-cycle latency.
- Overflow: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Handshake: hold div_valid high with changing operands during busy -> operands ignored; issue a second request in the div_outvalid cycle -> accepted; first results seen for one cycle; second result after 34 more cycles.
- Assert reset at iteration 10 -> div_ready=1 and div_outvalid=0 before the next edge; no outvalid pulse follows; next request computes correctly.

Source files
------------

// File: rtl/ysyx_23060236_div_pkg.sv
// Shared constants for the EXU multi-cycle arithmetic units (multiplier and divider).
package ysyx_23060236_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

endpackage

// File: rtl/ysyx_23060236_negabs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module ysyx_23060236_negabs
    import ysyx_23060236_div_pkg::*;
(
    input  logic [XLEN-1:0] value,
    input  logic            negate,
    output logic [XLEN-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/ysyx_23060236_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// quotient and remainder produced together behind a valid/ready request, outvalid pulse result.
module ysyx_23060236_div
    import ysyx_23060236_div_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_outvalid
);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  div_mag;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic [XLEN-1:0]  quotient_r;
    logic [XLEN-1:0]  remainder_r;
    logic             outvalid_r;

    logic             sd;
    logic             sv;
    logic [XLEN-1:0]  dividend_abs;
    logic [XLEN-1:0]  divisor_abs;
    logic             accept;
    logic             iterate;
    logic             finish;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    trial;
    logic             trial_ok;
    logic [XLEN-1:0]  quo_fixed;
    logic [XLEN-1:0]  rem_fixed;

    assign sd = div_signed & dividend[XLEN-1];
    assign sv = div_signed & divisor[XLEN-1];

    ysyx_23060236_negabs u_abs_dividend (
        .value  (dividend),
        .negate (sd),
        .result (dividend_abs)
    );

    ysyx_23060236_negabs u_abs_divisor (
        .value  (divisor),
        .negate (sv),
        .result (divisor_abs)
    );

    assign accept  = div_valid & ~busy;
    assign iterate = busy & ~count[CNT_W-1];
    assign finish  = busy &  count[CNT_W-1];

    // The partial remainder always stays below the divisor, so it fits in XLEN bits;
    // only the shifted value needs the extra bit for the trial subtraction.
    assign rem_sh   = {rem, quo[XLEN-1]};
    assign trial    = rem_sh - {1'b0, div_mag};
    assign trial_ok = ~trial[XLEN];

    ysyx_23060236_negabs u_fix_quo (
        .value  (quo),
        .negate (q_neg),
        .result (quo_fixed)
    );

    // With a zero divisor every trial succeeds and the whole magnitude ends up in rem,
    // so re-applying the dividend sign restores the original dividend unchanged.
    ysyx_23060236_negabs u_fix_rem (
        .value  (rem),
        .negate (r_neg),
        .result (rem_fixed)
    );

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the datapath registers are reset along with the control state so the
        // result outputs read zero out of reset instead of arbitrary power-up contents.
        if (reset) begin
            busy        <= 1'b0;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            div_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            outvalid_r  <= 1'b0;
        end else begin
            outvalid_r <= 1'b0;
            if (accept) begin
                busy        <= 1'b1;
                count       <= '0;
                rem         <= '0;
                quo         <= dividend_abs;
                div_mag     <= divisor_abs;
                q_neg       <= sd ^ sv;
                r_neg       <= sd;
                dz          <= (divisor == '0);
                quotient_r  <= '0;
                remainder_r <= '0;
            end else if (iterate) begin
                rem   <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                quo   <= {quo[XLEN-2:0], trial_ok};
                count <= count + CNT_W'(1);
            end else if (finish) begin
                quotient_r  <= dz ? '1 : quo_fixed;
                remainder_r <= rem_fixed;
                busy        <= 1'b0;
                count       <= '0;
                outvalid_r  <= 1'b1;
            end
        end
    end

    assign div_ready    = ~busy;
    assign div_outvalid = outvalid_r;
    assign quotient     = quotient_r;
    assign remainder    = remainder_r;

endmodule
